div_iter_responder: RTL and testbench

- Iterative radix-2 restoring divider. It is the responder end of the divisor/dividend/dout stream handshake that the execute stage drives for div.w/mod.w/div.wu/mod.wu.
- The core replaces the vendor divider IP. The execute stage instantiates one signed copy and one unsigned copy.
- Accepts one operand pair, computes the quotient and remainder over WIDTH cycles, then presents them packed on dout.

---
 rtl/div_iter_responder.sv | 142 ++++++++++++++
 tb/tb_div_iter_responder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_iter_responder.sv
// div_iter_responder: iterative radix-2 restoring divider, responder side of the
// dividend/divisor/dout stream handshake. One operand pair is taken, WIDTH
// CALC cycles follow, and {quotient, remainder} is then presented registered.
// Optional build macro: DIV_DOUT_TREADY_EN adds m_axis_dout_tready so the
// result is held until consumed.
`timescale 1ns/1ps
module div_iter_responder #(
    parameter int WIDTH  = 32,
    parameter int SIGNED = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [WIDTH-1:0]     s_axis_dividend_tdata,
    input  logic                 s_axis_dividend_tvalid,
    output logic                 s_axis_dividend_tready,
    input  logic [WIDTH-1:0]     s_axis_divisor_tdata,
    input  logic                 s_axis_divisor_tvalid,
    output logic                 s_axis_divisor_tready,
    output logic [2*WIDTH-1:0]   m_axis_dout_tdata,
    output logic                 m_axis_dout_tvalid
`ifdef DIV_DOUT_TREADY_EN
    ,
    input  logic                 m_axis_dout_tready
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state_reg;
    logic [WIDTH-1:0]     rem_reg;      // partial remainder
    logic [WIDTH-1:0]     quo_reg;      // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0]     dvs_reg;      // divisor magnitude
    logic                 q_neg_reg;
    logic                 r_neg_reg;
    logic [CW-1:0]        cnt_reg;
    logic                 ready_reg;
    logic                 valid_reg;
    logic [2*WIDTH-1:0]   dout_reg;

    logic                 accept;
    logic                 dout_take;
    logic                 dvd_neg;
    logic                 dvs_neg;
    logic [WIDTH-1:0]     dvd_mag;
    logic [WIDTH-1:0]     dvs_mag;
    logic [WIDTH:0]       shifted;
    logic [WIDTH:0]       trial;
    logic                 q_bit;
    logic [WIDTH-1:0]     rem_next;
    logic [WIDTH-1:0]     quo_next;
    logic [WIDTH-1:0]     quo_final;
    logic [WIDTH-1:0]     rem_final;

    assign s_axis_dividend_tready = ready_reg;
    assign s_axis_divisor_tready  = ready_reg;
    assign m_axis_dout_tdata      = dout_reg;
    assign m_axis_dout_tvalid     = valid_reg;

    // Handshake qualifiers, operand magnitudes and one restoring-division step
    always_comb begin
        accept  = ready_reg && s_axis_dividend_tvalid && s_axis_divisor_tvalid;
`ifdef DIV_DOUT_TREADY_EN
        dout_take = (state_reg == DONE) && valid_reg && m_axis_dout_tready;
`else
        dout_take = 1'b0;
`endif
        dvd_neg = (SIGNED != 0) && s_axis_dividend_tdata[WIDTH-1];
        dvs_neg = (SIGNED != 0) && s_axis_divisor_tdata[WIDTH-1];
        dvd_mag = dvd_neg ? -s_axis_dividend_tdata : s_axis_dividend_tdata;
        dvs_mag = dvs_neg ? -s_axis_divisor_tdata : s_axis_divisor_tdata;

        // Trial subtraction is one bit wider so its MSB is the borrow
        shifted  = {rem_reg, quo_reg[WIDTH-1]};
        trial    = shifted - {1'b0, dvs_reg};
        q_bit    = ~trial[WIDTH];
        rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_next = {quo_reg[WIDTH-2:0], q_bit};

        quo_final = q_neg_reg ? -quo_next : quo_next;
        rem_final = r_neg_reg ? -rem_next : rem_next;
    end

    // Control FSM with datapath registers and registered outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg <= IDLE;
            ready_reg <= 1'b1;
            valid_reg <= 1'b0;
            dout_reg  <= '0;
            cnt_reg   <= '0;
            rem_reg   <= '0;
            quo_reg   <= '0;
            dvs_reg   <= '0;
            q_neg_reg <= 1'b0;
            r_neg_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (accept) begin
                        state_reg <= CALC;
                        ready_reg <= 1'b0;
                        valid_reg <= 1'b0;
                        quo_reg   <= dvd_mag;
                        dvs_reg   <= dvs_mag;
                        rem_reg   <= '0;
                        // A zero divisor keeps the all-ones quotient uncorrected
                        q_neg_reg <= (dvd_neg ^ dvs_neg) && (dvs_mag != '0);
                        r_neg_reg <= dvd_neg;
                        cnt_reg   <= CW'(WIDTH);
                    end else if (dout_take) begin
                        state_reg <= IDLE;
                        ready_reg <= 1'b1;
                        valid_reg <= 1'b0;
                    end
                end
                CALC: begin
                    rem_reg <= rem_next;
                    quo_reg <= quo_next;
                    cnt_reg <= cnt_reg - CW'(1);
                    if (cnt_reg == CW'(1)) begin
                        state_reg <= DONE;
                        valid_reg <= 1'b1;
                        dout_reg  <= {quo_final, rem_final};
`ifdef DIV_DOUT_TREADY_EN
                        ready_reg <= 1'b0;
`else
                        ready_reg <= 1'b1;
`endif
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter_responder.sv
// Bench for div_iter_responder: a signed and an unsigned copy share stimulus;
// results are compared with an arithmetic reference model and spec vectors.
`timescale 1ns/1ps
module tb_div_iter_responder;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic [W-1:0]   dvd = '0;
    logic [W-1:0]   dvs = '0;
    logic           dvd_v = 1'b0;
    logic           dvs_v = 1'b0;
    logic           dvd_r_s, dvs_r_s, dvd_r_u, dvs_r_u;
    logic [2*W-1:0] dout_s, dout_u;
    logic           dv_s, dv_u;
`ifdef DIV_DOUT_TREADY_EN
    logic           dout_rdy = 1'b1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_iter_responder #(.WIDTH(W), .SIGNED(1)) u_s (
        .clk                    (clk),
        .resetn                 (resetn),
        .s_axis_dividend_tdata  (dvd),
        .s_axis_dividend_tvalid (dvd_v),
        .s_axis_dividend_tready (dvd_r_s),
        .s_axis_divisor_tdata   (dvs),
        .s_axis_divisor_tvalid  (dvs_v),
        .s_axis_divisor_tready  (dvs_r_s),
        .m_axis_dout_tdata      (dout_s),
        .m_axis_dout_tvalid     (dv_s)
`ifdef DIV_DOUT_TREADY_EN
        ,
        .m_axis_dout_tready     (dout_rdy)
`endif
    );

    div_iter_responder #(.WIDTH(W), .SIGNED(0)) u_u (
        .clk                    (clk),
        .resetn                 (resetn),
        .s_axis_dividend_tdata  (dvd),
        .s_axis_dividend_tvalid (dvd_v),
        .s_axis_dividend_tready (dvd_r_u),
        .s_axis_divisor_tdata   (dvs),
        .s_axis_divisor_tvalid  (dvs_v),
        .s_axis_divisor_tready  (dvs_r_u),
        .m_axis_dout_tdata      (dout_u),
        .m_axis_dout_tvalid     (dv_u)
`ifdef DIV_DOUT_TREADY_EN
        ,
        .m_axis_dout_tready     (dout_rdy)
`endif
    );

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        bit             sgn;
        logic [2*W-1:0] exp;
    } vec_t;

    vec_t tbl[9];

    // Reference: plain arithmetic with the two documented special cases
    function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input bit sgn);
        logic [W-1:0] q;
        logic [W-1:0] r;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = '0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Wait (bounded) until both copies are ready, at a falling edge
    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!(dvd_r_s && dvs_r_s && dvd_r_u && dvs_r_u) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_op", {63'd0, (n < 100)}, 64'd1);
    endtask

    // One full operation: accept at edge 0, quiet through cycle 32, result at 33
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [2*W-1:0] rs, output logic [2*W-1:0] ru);
        bit early;
        wait_ready();
        dvd = a; dvs = b; dvd_v = 1'b1; dvs_v = 1'b1;
        @(posedge clk);
        #1;
        dvd_v = 1'b0; dvs_v = 1'b0;
        early = 1'b0;
        for (int k = 1; k <= W; k++) begin
            @(negedge clk);
            if (dv_s || dv_u || dvd_r_s || dvs_r_u) early = 1'b1;
            dvd = $urandom; dvs = $urandom;
        end
        chk("calc_quiet", {63'd0, early}, 64'd0);
        @(negedge clk);
        chk("valid_s_at_33", {63'd0, dv_s}, 64'd1);
        chk("valid_u_at_33", {63'd0, dv_u}, 64'd1);
        rs = dout_s;
        ru = dout_u;
        $display("op a=%h b=%h signed=%h unsigned=%h", a, b, rs, ru);
    endtask

    initial begin
        logic [2*W-1:0] rs, ru, hold;
        logic [W-1:0]   a, b;
        bit             bad;

        tbl[0] = '{32'd7,          32'd2,          1'b1, {32'h0000_0003, 32'h0000_0001}};
        tbl[1] = '{32'hFFFF_FFF9,  32'd2,          1'b1, {32'hFFFF_FFFD, 32'hFFFF_FFFF}};
        tbl[2] = '{32'd7,          32'hFFFF_FFFE,  1'b1, {32'hFFFF_FFFD, 32'h0000_0001}};
        tbl[3] = '{32'hFFFF_FFFF,  32'h10,         1'b0, {32'h0FFF_FFFF, 32'h0000_000F}};
        tbl[4] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, {32'h8000_0000, 32'h0000_0000}};
        tbl[5] = '{32'h1234_5678,  32'd0,          1'b1, {32'hFFFF_FFFF, 32'h1234_5678}};
        tbl[6] = '{32'h1234_5678,  32'd0,          1'b0, {32'hFFFF_FFFF, 32'h1234_5678}};
        tbl[7] = '{32'd0,          32'd5,          1'b1, {32'h0000_0000, 32'h0000_0000}};
        tbl[8] = '{32'd9,          32'd4,          1'b0, {32'h0000_0002, 32'h0000_0001}};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready_s", {62'd0, dvd_r_s, dvs_r_s}, 64'd3);
        chk("rst_ready_u", {62'd0, dvd_r_u, dvs_r_u}, 64'd3);
        chk("rst_valid", {62'd0, dv_s, dv_u}, 64'd0);
        chk("rst_dout_s", dout_s, 64'd0);
        chk("rst_dout_u", dout_u, 64'd0);
        resetn = 1'b1;

        // Only one channel valid: nothing may be accepted
        @(negedge clk);
        dvd = 32'd5; dvs = 32'd1; dvd_v = 1'b1; dvs_v = 1'b0;
        repeat (3) @(negedge clk);
        chk("one_valid_no_accept", {61'd0, dvd_r_s, dvd_r_u, dv_s}, 64'd6);
        dvd_v = 1'b0;

        // Spec vectors
        for (int i = 0; i < 9; i++) begin
            do_op(tbl[i].a, tbl[i].b, rs, ru);
            if (tbl[i].sgn) begin
                chk("vec_signed", rs, tbl[i].exp);
                chk("vec_unsigned_model", ru, ref_div(tbl[i].a, tbl[i].b, 1'b0));
            end else begin
                chk("vec_unsigned", ru, tbl[i].exp);
                chk("vec_signed_model", rs, ref_div(tbl[i].a, tbl[i].b, 1'b1));
            end
        end

        // Randomized operands with a bias toward boundary values
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0:       a = 32'h8000_0000;
                1:       a = $urandom_range(0, 20);
                2:       a = 32'hFFFF_FFFF - $urandom_range(0, 20);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       b = '0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = $urandom_range(1, 15);
                3:       b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            do_op(a, b, rs, ru);
            chk("rand_signed", rs, ref_div(a, b, 1'b1));
            chk("rand_unsigned", ru, ref_div(a, b, 1'b0));
        end

        // Reset in the middle of CALC discards the operation
        wait_ready();
        dvd = 32'd100; dvs = 32'd3; dvd_v = 1'b1; dvs_v = 1'b1;
        @(posedge clk);
        #1;
        dvd_v = 1'b0; dvs_v = 1'b0;
        repeat (10) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        chk("midrst_valid", {62'd0, dv_s, dv_u}, 64'd0);
        chk("midrst_ready", {62'd0, dvd_r_s, dvs_u_ready()}, 64'd3);
        chk("midrst_dout", dout_s, 64'd0);
        resetn = 1'b1;
        do_op(32'd9, 32'd4, rs, ru);
        chk("after_rst_signed", rs, {32'd2, 32'd1});
        chk("after_rst_unsigned", ru, {32'd2, 32'd1});

`ifdef DIV_DOUT_TREADY_EN
        // Result held until consumed; operands blocked meanwhile
        dout_rdy = 1'b0;
        wait_ready();
        dvd = 32'd1000; dvs = 32'd7; dvd_v = 1'b1; dvs_v = 1'b1;
        @(posedge clk);
        #1;
        dvd = 32'd50; dvs = 32'd6;
        repeat (W + 1) @(negedge clk);
        chk("hold_valid", {63'd0, dv_s}, 64'd1);
        chk("hold_data", dout_s, ref_div(32'd1000, 32'd7, 1'b1));
        hold = dout_s;
        bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (!dv_s || dout_s !== hold || dvd_r_s || dvs_r_s) bad = 1'b1;
        end
        chk("hold_stable", {63'd0, bad}, 64'd0);
        dout_rdy = 1'b1;
        @(negedge clk);
        chk("consume_drop", {62'd0, dv_s, dvd_r_s}, 64'd1);
        @(negedge clk);
        chk("reaccept", {63'd0, dvd_r_s}, 64'd0);
        dvd_v = 1'b0; dvs_v = 1'b0;
        repeat (W) @(negedge clk);
        chk("reaccept_data", dout_s, ref_div(32'd50, 32'd6, 1'b1));
        $display("op held result=%h next=%h", hold, dout_s);
`else
        // Valid held high: next pair accepted on the first DONE edge
        wait_ready();
        dvd = 32'd100; dvs = 32'd7; dvd_v = 1'b1; dvs_v = 1'b1;
        @(posedge clk);
        repeat (W + 1) @(negedge clk);
        chk("b2b_first_valid", {63'd0, dv_s}, 64'd1);
        chk("b2b_first_data", dout_s, ref_div(32'd100, 32'd7, 1'b1));
        dvd = 32'hFFFF_FF00; dvs = 32'd3;
        @(negedge clk);
        chk("b2b_one_cycle", {62'd0, dv_s, dvd_r_s}, 64'd0);
        repeat (W) @(negedge clk);
        dvd_v = 1'b0; dvs_v = 1'b0;
        chk("b2b_second_valid", {63'd0, dv_s}, 64'd1);
        chk("b2b_second_data", dout_s, ref_div(32'hFFFF_FF00, 32'd3, 1'b1));
        chk("b2b_second_data_u", dout_u, ref_div(32'hFFFF_FF00, 32'd3, 1'b0));
        $display("op back-to-back signed=%h unsigned=%h", dout_s, dout_u);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    function automatic logic dvs_u_ready();
        return dvs_r_u;
    endfunction

endmodule
